// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if
// Bundles every signal between the shift-add multiply sequencer, the core
// that requests multiplies, and the 8-bit ALU the sequencer borrows.
//   start, mcand, mplier : multiply request from the core
//   busy, done, product  : status and result back to the core
//   alu_a, alu_b, alu_op : operands and opcode driven to the ALU
//   alu_out, alu_flg     : combinational ALU result and flags (bit 0 = carry)
// The slave modport is the sequencer; the master modport is the
// core plus ALU side that surrounds it.
interface alu_mul_seq_if;
  logic        start;
  logic [7:0]  mcand;
  logic [7:0]  mplier;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_op;
  logic [7:0]  alu_out;
  logic [7:0]  alu_flg;

  modport slave (
    input  start, mcand, mplier, alu_out, alu_flg,
    output busy, done, product, alu_a, alu_b, alu_op
  );

  modport master (
    output start, mcand, mplier, alu_out, alu_flg,
    input  busy, done, product, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq
// Multi-cycle 8x8 unsigned shift-add multiplier that reuses the datapath
// ALU instead of owning multiplier hardware. Each of the 8 iterations takes
// an ADD cycle (hi += lo[0] ? mc : 0, carry captured) followed by a SHIFT
// cycle (the {cy, hi, lo} chain moves right by one bit).
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : alu_mul_seq_if slave modport (request, status, product, ALU link)
module alu_mul_seq #(
  parameter logic [3:0] OP_ADD = 4'b0000,
  parameter logic [3:0] OP_SHR = 4'b0101
) (
  input logic         clk,
  input logic         rst,
  alu_mul_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  state_t     state, state_next;
  logic [7:0] mc, mc_next;
  logic [7:0] hi, hi_next;
  logic [7:0] lo, lo_next;
  logic       cy, cy_next;
  logic [2:0] cnt, cnt_next;

  logic [7:0] alu_a_c;
  logic [7:0] alu_b_c;
  logic [3:0] alu_op_c;

  // State and datapath registers; reset wins over any start on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mc    <= 8'h00;
      hi    <= 8'h00;
      lo    <= 8'h00;
      cy    <= 1'b0;
      cnt   <= 3'd0;
    end else begin
      state <= state_next;
      mc    <= mc_next;
      hi    <= hi_next;
      lo    <= lo_next;
      cy    <= cy_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and ALU drive. The ADD step runs even when the multiplier
  // bit is 0 (B forced to zero) so latency never depends on the data.
  // In SHIFT the ALU shifts hi right; bit 7 is refilled from the carry
  // captured during ADD, and hi[0] falls into the top of lo.
  always_comb begin
    state_next = state;
    mc_next    = mc;
    hi_next    = hi;
    lo_next    = lo;
    cy_next    = cy;
    cnt_next   = cnt;
    alu_a_c    = 8'h00;
    alu_b_c    = 8'h00;
    alu_op_c   = OP_ADD;

    case (state)
      IDLE: begin
        if (bus.start) begin
          mc_next    = bus.mcand;
          hi_next    = 8'h00;
          lo_next    = bus.mplier;
          cy_next    = 1'b0;
          cnt_next   = 3'd0;
          state_next = ADD;
        end
      end
      ADD: begin
        alu_a_c    = hi;
        alu_b_c    = lo[0] ? mc : 8'h00;
        alu_op_c   = OP_ADD;
        hi_next    = bus.alu_out;
        cy_next    = bus.alu_flg[0];
        state_next = SHIFT;
      end
      SHIFT: begin
        alu_a_c    = hi;
        alu_b_c    = 8'h00;
        alu_op_c   = OP_SHR;
        hi_next    = {cy, bus.alu_out[6:0]};
        lo_next    = {hi[0], lo[7:1]};
        cy_next    = 1'b0;
        cnt_next   = cnt + 3'd1;
        state_next = (cnt == 3'd7) ? DONE : ADD;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.alu_a   = alu_a_c;
  assign bus.alu_b   = alu_b_c;
  assign bus.alu_op  = alu_op_c;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.product = {hi, lo};

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq
// Directed bench for alu_mul_seq with a combinational ALU model on the
// interface and a step-by-step shift-add reference for the per-cycle
// ALU drive checks. Final products are hand-computed constants.
module tb_alu_mul_seq;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [7:0] m_mc;
  logic [7:0] m_hi;
  logic [7:0] m_lo;
  logic       m_cy;

  alu_mul_seq_if bus ();

  alu_mul_seq #(.OP_ADD(4'b0000), .OP_SHR(4'b0101)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Minimal ALU: ADD reports carry in flag bit 0, SHR is a zero-fill shift.
  always_comb begin
    logic [8:0] sum;
    sum         = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    bus.alu_out = 8'h00;
    bus.alu_flg = 8'h00;
    case (bus.alu_op)
      4'b0000: begin
        bus.alu_out = sum[7:0];
        bus.alu_flg = {7'b0, sum[8]};
      end
      4'b0101: begin
        bus.alu_out = bus.alu_a >> 1;
        bus.alu_flg = {7'b0, bus.alu_a[0]};
      end
      default: begin
        bus.alu_out = 8'h00;
        bus.alu_flg = 8'h00;
      end
    endcase
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive a request and clock the accepting edge; leaves us 1 unit after it.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    bus.mcand  = a;
    bus.mplier = b;
    bus.start  = 1'b1;
    m_mc = a;
    m_lo = b;
    m_hi = 8'h00;
    m_cy = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // One busy cycle: check status and ALU drive against the reference,
  // advance the reference, then clock the next edge.
  task automatic stepCycle(input int c, input string tag);
    logic [7:0] exp_b;
    logic [8:0] sum;
    checkOutput($sformatf("%s c%0d busy", tag, c), {15'b0, bus.busy}, 16'd1);
    checkOutput($sformatf("%s c%0d done", tag, c), {15'b0, bus.done}, 16'd0);
    if (c % 2 == 1) begin
      exp_b = m_lo[0] ? m_mc : 8'h00;
      checkOutput($sformatf("%s c%0d add_op", tag, c), {12'b0, bus.alu_op}, 16'h0000);
      checkOutput($sformatf("%s c%0d add_a", tag, c), {8'b0, bus.alu_a}, {8'b0, m_hi});
      checkOutput($sformatf("%s c%0d add_b", tag, c), {8'b0, bus.alu_b}, {8'b0, exp_b});
      sum  = {1'b0, m_hi} + {1'b0, exp_b};
      m_hi = sum[7:0];
      m_cy = sum[8];
    end else begin
      checkOutput($sformatf("%s c%0d shr_op", tag, c), {12'b0, bus.alu_op}, 16'h0005);
      checkOutput($sformatf("%s c%0d shr_a", tag, c), {8'b0, bus.alu_a}, {8'b0, m_hi});
      checkOutput($sformatf("%s c%0d shr_b", tag, c), {8'b0, bus.alu_b}, 16'h0000);
      m_lo = {m_hi[0], m_lo[7:1]};
      m_hi = {m_cy, m_hi[7:1]};
      m_cy = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Full multiply after the accept edge. inject_at > 0 raises start with
  // 0xFF x 0xFF mid-operation and leaves it high.
  task automatic runBody(input logic [15:0] exp_prod, input string tag,
                         input int inject_at);
    for (int c = 1; c <= 16; c++) begin
      if (c == inject_at) begin
        bus.start  = 1'b1;
        bus.mcand  = 8'hFF;
        bus.mplier = 8'hFF;
      end
      stepCycle(c, tag);
    end
    checkOutput({tag, " done_pulse"}, {15'b0, bus.done}, 16'd1);
    checkOutput({tag, " done_busy"}, {15'b0, bus.busy}, 16'd1);
    checkOutput({tag, " product"}, bus.product, exp_prod);
    checkOutput({tag, " done_op"}, {12'b0, bus.alu_op}, 16'h0000);
    checkOutput({tag, " done_a"}, {8'b0, bus.alu_a}, 16'h0000);
    @(posedge clk);
    #1;
    checkOutput({tag, " idle_done"}, {15'b0, bus.done}, 16'd0);
    checkOutput({tag, " idle_busy"}, {15'b0, bus.busy}, 16'd0);
    checkOutput({tag, " product_hold"}, bus.product, exp_prod);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    m_mc       = 8'h00;
    m_hi       = 8'h00;
    m_lo       = 8'h00;
    m_cy       = 1'b0;
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.mcand  = 8'h55;
    bus.mplier = 8'h55;

    // Reset held three cycles with start high: nothing may be accepted.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("reset busy", {15'b0, bus.busy}, 16'd0);
      checkOutput("reset done", {15'b0, bus.done}, 16'd0);
      checkOutput("reset product", bus.product, 16'h0000);
      checkOutput("reset alu_op", {12'b0, bus.alu_op}, 16'h0000);
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_reset busy", {15'b0, bus.busy}, 16'd0);

    applyStimulus(8'h0D, 8'h0B);
    runBody(16'h008F, "mul_0d_0b", 0);

    applyStimulus(8'hFF, 8'hFF);
    runBody(16'hFE01, "mul_ff_ff", 0);

    applyStimulus(8'h80, 8'h02);
    runBody(16'h0100, "mul_80_02", 0);

    applyStimulus(8'h00, 8'hA5);
    runBody(16'h0000, "mul_00_a5", 0);

    // Start during operation is ignored; held start is taken once idle.
    applyStimulus(8'h03, 8'h05);
    runBody(16'h000F, "mul_03_05_ign", 5);
    applyStimulus(8'hFF, 8'hFF);
    runBody(16'hFE01, "mul_held", 0);

    // Reset mid-operation discards the product and suppresses done.
    applyStimulus(8'h12, 8'h34);
    for (int c = 1; c <= 6; c++) stepCycle(c, "mul_12_34_rst");
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.mcand  = 8'hFF;
    bus.mplier = 8'hFF;
    @(posedge clk);
    #1;
    checkOutput("midrst busy", {15'b0, bus.busy}, 16'd0);
    checkOutput("midrst product", bus.product, 16'h0000);
    checkOutput("midrst done", {15'b0, bus.done}, 16'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("midrst quiet%0d done", i), {15'b0, bus.done}, 16'd0);
      checkOutput($sformatf("midrst quiet%0d busy", i), {15'b0, bus.busy}, 16'd0);
    end
    applyStimulus(8'h12, 8'h34);
    runBody(16'h03A8, "mul_12_34", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
